// File: rtl/slv_sram_bridge.sv
// Slave-bus to single-port synchronous SRAM bridge with programmable wait states.
// Define SRAM_BWE_EN to drive SRAM byte write enables (single-access partial writes) instead of read-modify-write.
//
// state | meaning
// IDLE  | waiting for iSlvReq, latches the transaction on accept
// RD    | SRAM read access (Ce=1, We=0)
// RDCAP | capture iMemRData: read data to master, or merge for a partial write
// WR    | SRAM write access (Ce=1, We=1)
// WAIT  | counting down the latched wait states
// ACK   | one-cycle completion pulse, iSlvReq ignored
module slv_sram_bridge #(
   parameter int CMD_W = 1,
   parameter int AW    = 10,
   parameter int DW    = 32,
   parameter int SW    = 4
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iSlvReq,
   input  logic [CMD_W-1:0] iSlvCmd,
   input  logic [AW-1:0]    iSlvAddr,
   input  logic [SW-1:0]    iSlvSel,
   input  logic [DW-1:0]    iSlvWData,
   output logic             oSlvAck,
   output logic [DW-1:0]    oSlvRData,
   input  logic [3:0]       iWaitCyc,
   output logic             oMemCe,
   output logic             oMemWe,
   output logic [AW-1:0]    oMemAddr,
   output logic [DW-1:0]    oMemWData,
`ifdef SRAM_BWE_EN
   output logic [SW-1:0]    oMemBwe,
`endif
   input  logic [DW-1:0]    iMemRData
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RD    = 3'd1;
   localparam logic [2:0] RDCAP = 3'd2;
   localparam logic [2:0] WR    = 3'd3;
   localparam logic [2:0] WAIT  = 3'd4;
   localparam logic [2:0] ACK   = 3'd5;

`ifdef SRAM_BWE_EN
   localparam logic BWE_EN = 1'b1;
`else
   localparam logic BWE_EN = 1'b0;
`endif

   logic [2:0]    state, stateNxt;
   logic [3:0]    waitCnt, waitCntNxt;
   logic [3:0]    waitQ;
   logic [3:0]    postWait;
   logic          isWrQ;
   logic [SW-1:0] selQ;
   logic [DW-1:0] wdataQ;
   logic [DW-1:0] merged;
   logic          reqWr;
   logic          accept;
   logic          accessDone;
   logic          ackNxt, ceNxt, weNxt;
   logic [DW-1:0] rdataNxt, memWDataNxt;
`ifdef SRAM_BWE_EN
   logic [SW-1:0] bweNxt;
`endif

   assign reqWr  = (iSlvCmd == CMD_W'(1));
   assign accept = (state == IDLE) && iSlvReq;

   always_comb begin
      merged = iMemRData;
      for (int b = 0; b < SW; b++) begin
         if (selQ[b]) merged[8*b +: 8] = wdataQ[8*b +: 8];
      end
   end

   always_comb begin
      stateNxt    = state;
      waitCntNxt  = waitCnt;
      ackNxt      = 1'b0;
      ceNxt       = 1'b0;
      weNxt       = 1'b0;
      rdataNxt    = oSlvRData;
      memWDataNxt = oMemWData;
      accessDone  = 1'b0;
      postWait    = waitQ;
`ifdef SRAM_BWE_EN
      bweNxt      = '0;
`endif
      case (state)
         IDLE: begin
            if (iSlvReq) begin
               postWait = iWaitCyc;
               // an empty write has nothing to store, so no SRAM cycle at all
               if (reqWr && (iSlvSel == '0)) begin
                  accessDone = 1'b1;
               end else if (reqWr && ((iSlvSel == '1) || BWE_EN)) begin
                  stateNxt    = WR;
                  ceNxt       = 1'b1;
                  weNxt       = 1'b1;
                  memWDataNxt = iSlvWData;
`ifdef SRAM_BWE_EN
                  bweNxt      = iSlvSel;
`endif
               end else begin
                  stateNxt = RD;
                  ceNxt    = 1'b1;
               end
            end
         end
         RD: stateNxt = RDCAP;
         RDCAP: begin
            if (isWrQ) begin
               stateNxt    = WR;
               ceNxt       = 1'b1;
               weNxt       = 1'b1;
               memWDataNxt = merged;
`ifdef SRAM_BWE_EN
               bweNxt      = selQ;
`endif
            end else begin
               rdataNxt   = iMemRData;
               accessDone = 1'b1;
            end
         end
         WR: accessDone = 1'b1;
         WAIT: begin
            if (waitCnt == 4'd0) begin
               stateNxt = ACK;
               ackNxt   = 1'b1;
            end else begin
               waitCntNxt = waitCnt - 4'd1;
            end
         end
         ACK: stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
      if (accessDone) begin
         if (postWait == 4'd0) begin
            stateNxt = ACK;
            ackNxt   = 1'b1;
         end else begin
            stateNxt   = WAIT;
            waitCntNxt = postWait - 4'd1;
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state     <= IDLE;
         waitCnt   <= 4'd0;
         waitQ     <= 4'd0;
         isWrQ     <= 1'b0;
         selQ      <= '0;
         wdataQ    <= '0;
         oSlvAck   <= 1'b0;
         oSlvRData <= '0;
         oMemCe    <= 1'b0;
         oMemWe    <= 1'b0;
         oMemAddr  <= '0;
         oMemWData <= '0;
`ifdef SRAM_BWE_EN
         oMemBwe   <= '0;
`endif
      end else begin
         state     <= stateNxt;
         waitCnt   <= waitCntNxt;
         oSlvAck   <= ackNxt;
         oSlvRData <= rdataNxt;
         oMemCe    <= ceNxt;
         oMemWe    <= weNxt;
         oMemWData <= memWDataNxt;
`ifdef SRAM_BWE_EN
         oMemBwe   <= bweNxt;
`endif
         if (accept) begin
            isWrQ    <= reqWr;
            selQ     <= iSlvSel;
            wdataQ   <= iSlvWData;
            waitQ    <= iWaitCyc;
            oMemAddr <= iSlvAddr;
         end
      end
   end

endmodule

// File: tb/tb_slv_sram_bridge.sv
// Bench for slv_sram_bridge: SRAM model, transaction-level reference memory, directed and random traffic.
// Build with +define+SRAM_BWE_EN to exercise the byte-write-enable variant.
module tb_slv_sram_bridge;

   logic        iClk;
   logic        iRst;
   logic        iSlvReq;
   logic [0:0]  iSlvCmd;
   logic [9:0]  iSlvAddr;
   logic [3:0]  iSlvSel;
   logic [31:0] iSlvWData;
   logic        oSlvAck;
   logic [31:0] oSlvRData;
   logic [3:0]  iWaitCyc;
   logic        oMemCe;
   logic        oMemWe;
   logic [9:0]  oMemAddr;
   logic [31:0] oMemWData;
   logic [3:0]  oMemBwe;
   logic [31:0] iMemRData;

   int total = 0;
   int bad   = 0;
   logic [31:0] lastRd;
   logic [31:0] refMem [0:1023];
   logic [31:0] sramMem [0:1023];
   logic        memInit = 1'b0;

`ifdef SRAM_BWE_EN
   localparam bit BWE = 1'b1;
`else
   localparam bit BWE = 1'b0;
   assign oMemBwe = 4'hf;
`endif

   slv_sram_bridge #(.CMD_W(1), .AW(10), .DW(32), .SW(4)) dut (
      .iClk(iClk), .iRst(iRst), .iSlvReq(iSlvReq), .iSlvCmd(iSlvCmd),
      .iSlvAddr(iSlvAddr), .iSlvSel(iSlvSel), .iSlvWData(iSlvWData),
      .oSlvAck(oSlvAck), .oSlvRData(oSlvRData), .iWaitCyc(iWaitCyc),
      .oMemCe(oMemCe), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
`ifdef SRAM_BWE_EN
      .oMemBwe(oMemBwe),
`endif
      .iMemRData(iMemRData)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   function automatic logic [31:0] pat(int i);
      return (32'(i) * 32'h9E3779B9) ^ 32'(i << 8);
   endfunction

   function automatic logic [31:0] byteMask(logic [3:0] sel);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) if (sel[b]) m[8*b +: 8] = 8'hff;
      return m;
   endfunction

   // synchronous SRAM: read data appears the cycle after a read enable
   always @(posedge iClk) begin
      if (!memInit) begin
         for (int i = 0; i < 1024; i++) sramMem[i] <= pat(i);
         memInit <= 1'b1;
      end else if (oMemCe) begin
         if (oMemWe) begin
            for (int b = 0; b < 4; b++)
               if (oMemBwe[b]) sramMem[oMemAddr][8*b +: 8] <= oMemWData[8*b +: 8];
         end else begin
            iMemRData <= sramMem[oMemAddr];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   // One transaction from an idle DUT; the presentation cycle is N, Ack expected at N+lat.
   task automatic doTxn(input string tag, input logic cmd, input logic [9:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd, input logic [3:0] w);
      int k, lat, ceCnt, weCnt, expLat, expCe, expWe;
      bit got;
      logic [31:0] expRd, newRef;
      expRd  = refMem[addr];
      newRef = (refMem[addr] & ~byteMask(sel)) | (wd & byteMask(sel));
      if (!cmd) begin
         expLat = 3 + int'(w); expCe = 1; expWe = 0;
      end else if (sel == 4'hf || BWE) begin
         expLat = 2 + int'(w); expCe = 1; expWe = 1;
      end else begin
         expLat = 4 + int'(w); expCe = 2; expWe = 1;
      end
      chk($sformatf("%s rdata-hold", tag), oSlvRData, lastRd);
      iSlvReq = 1'b1; iSlvCmd = cmd; iSlvAddr = addr; iSlvSel = sel;
      iSlvWData = wd; iWaitCyc = w;
      got = 0; lat = 0; ceCnt = 0; weCnt = 0;
      for (k = 1; k <= 40 && !got; k++) begin
         tick();
         if (oMemCe) begin
            ceCnt++;
            chk($sformatf("%s mem-addr", tag), 32'(oMemAddr), 32'(addr));
         end
         if (oMemWe) begin
            weCnt++;
            if (BWE) begin
               chk($sformatf("%s bwe", tag), 32'(oMemBwe), 32'(sel));
               chk($sformatf("%s wdata", tag), oMemWData & byteMask(sel), wd & byteMask(sel));
            end else begin
               chk($sformatf("%s wdata", tag), oMemWData, newRef);
            end
         end
         if (oSlvAck) begin
            got = 1; lat = k;
         end
         if (k == 1) begin
            iSlvCmd = ~cmd; iSlvAddr = 10'($urandom); iSlvSel = 4'($urandom);
            iSlvWData = $urandom; iWaitCyc = 4'd0;
         end
      end
      iSlvReq = 1'b0;
      chk($sformatf("%s ack-seen", tag), 32'(got), 32'd1);
      if (cmd && sel == 4'h0) begin
         chk($sformatf("%s no-write", tag), 32'(weCnt), 32'd0);
      end else begin
         chk($sformatf("%s latency", tag), 32'(lat), 32'(expLat));
         chk($sformatf("%s ce-count", tag), 32'(ceCnt), 32'(expCe));
         chk($sformatf("%s we-count", tag), 32'(weCnt), 32'(expWe));
      end
      if (cmd) begin
         refMem[addr] = newRef;
      end else begin
         chk($sformatf("%s rdata", tag), oSlvRData, expRd);
         lastRd = expRd;
      end
      tick();
      chk($sformatf("%s ack-pulse", tag), 32'(oSlvAck), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int ackCyc[$];
      int idx, k, adj, acks, wes;
      bit prevAck;
      logic [9:0] base;
      logic [3:0] s;
      for (int i = 0; i < 1024; i++) refMem[i] = pat(i);
      lastRd = '0;

      iRst = 1'b1; iSlvReq = 1'b1; iSlvCmd = 1'b1; iSlvAddr = 10'h3ff;
      iSlvSel = 4'hf; iSlvWData = 32'h0badf00d; iWaitCyc = 4'd0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst ack", 32'(oSlvAck), 32'd0);
         chk("rst ce", 32'(oMemCe), 32'd0);
         chk("rst we", 32'(oMemWe), 32'd0);
      end
      chk("rst rdata", oSlvRData, 32'd0);
      chk("rst memaddr", 32'(oMemAddr), 32'd0);
      chk("rst memwdata", oMemWData, 32'd0);
      chk("rst bwe", 32'(oMemBwe), BWE ? 32'd0 : 32'hf);
      iRst = 1'b0;
      doTxn("first-accept", 1'b1, 10'h3ff, 4'hf, 32'h0badf00d, 4'd0);

      doTxn("full-wr", 1'b1, 10'h005, 4'hf, 32'hDEADBEEF, 4'd0);
      doTxn("rd-back", 1'b0, 10'h005, 4'hf, 32'h0, 4'd0);
      chk("rd-back literal", oSlvRData, 32'hDEADBEEF);

      doTxn("preload", 1'b1, 10'h010, 4'hf, 32'h11223344, 4'd0);
      doTxn("partial-wr", 1'b1, 10'h010, 4'b0101, 32'hAABBCCDD, 4'd0);
      doTxn("partial-rd", 1'b0, 10'h010, 4'hf, 32'h0, 4'd0);
      chk("partial literal", oSlvRData, 32'h11BB33DD);

      doTxn("wait5-rd", 1'b0, 10'h010, 4'hf, 32'h0, 4'd5);
      doTxn("wait15-wr", 1'b1, 10'h011, 4'b1000, 32'h5a000000, 4'd15);
      doTxn("sel0-wr", 1'b1, 10'h005, 4'h0, 32'h12345678, 4'd2);
      doTxn("sel0-rd", 1'b0, 10'h005, 4'h0, 32'h0, 4'd0);

      for (int t = 0; t < 24; t++) begin
         case ($urandom_range(0, 3))
            0: s = 4'hf;
            1: s = 4'h0;
            default: s = 4'($urandom);
         endcase
         doTxn($sformatf("rand%0d", t), 1'($urandom), 10'($urandom_range(0, 15)), s,
               $urandom, 4'($urandom_range(0, 3)));
      end

      // back-to-back reads, request never dropped between transactions
      base = 10'h020;
      iSlvReq = 1'b1; iSlvCmd = 1'b0; iSlvAddr = base; iSlvSel = 4'($urandom);
      iWaitCyc = 4'd0;
      idx = 0; k = 0; adj = 0; prevAck = 0;
      while (idx < 16 && k < 200) begin
         tick();
         k++;
         if (oSlvAck && prevAck) adj++;
         prevAck = oSlvAck;
         if (oSlvAck) begin
            chk($sformatf("b2b rdata%0d", idx), oSlvRData, refMem[base + 10'(idx)]);
            ackCyc.push_back(k);
            idx++;
            iSlvAddr = base + 10'(idx);
            if (idx == 16) iSlvReq = 1'b0;
         end
      end
      iSlvReq = 1'b0;
      chk("b2b count", 32'(idx), 32'd16);
      chk("b2b adjacent", 32'(adj), 32'd0);
      if (ackCyc.size() > 0) chk("b2b first", 32'(ackCyc[0]), 32'd3);
      for (int i = 1; i < ackCyc.size(); i++)
         chk($sformatf("b2b spacing%0d", i), 32'(ackCyc[i] - ackCyc[i-1]), 32'd4);
      lastRd = refMem[base + 10'd15];
      tick();
      chk("b2b ack-end", 32'(oSlvAck), 32'd0);

      // reset during a partial write must leave the SRAM word untouched
      iSlvReq = 1'b1; iSlvCmd = 1'b1; iSlvAddr = 10'h011; iSlvSel = 4'b0011;
      iSlvWData = 32'hCAFE1234; iWaitCyc = 4'd0;
      if (BWE) begin
         iRst = 1'b1;
         tick();
         chk("rst-mid ce", 32'(oMemCe), 32'd0);
         chk("rst-mid we", 32'(oMemWe), 32'd0);
      end else begin
         tick();
         chk("rst-mid rd-ce", 32'(oMemCe), 32'd1);
         chk("rst-mid rd-we", 32'(oMemWe), 32'd0);
         tick();
         iRst = 1'b1;
         tick();
         chk("rst-mid ce", 32'(oMemCe), 32'd0);
         chk("rst-mid we", 32'(oMemWe), 32'd0);
         chk("rst-mid ack", 32'(oSlvAck), 32'd0);
      end
      iRst = 1'b0; iSlvReq = 1'b0;
      acks = 0; wes = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (oSlvAck) acks++;
         if (oMemWe) wes++;
      end
      chk("rst-mid no-ack", 32'(acks), 32'd0);
      chk("rst-mid no-write", 32'(wes), 32'd0);
      chk("rst-mid sram", sramMem[10'h011], refMem[10'h011]);
      lastRd = '0;
      doTxn("rst-mid readback", 1'b0, 10'h011, 4'hf, 32'h0, 4'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/slv_sram_bridge.md
SLV_SRAM_BRIDGE -- requirements
Module: slv_sram_bridge

Interface
REQ-001 SHALL have parameter CMD_W, default 1, command width; value 1 = write, value 0 = read.
REQ-002 SHALL have parameter AW, default 10, word-address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter SW, default 4, byte-select width; SW = DW/8.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- iClk  in  1  clock; all logic on the rising edge.
- iRst  in  1  synchronous reset, active-high.
- iSlvReq  in  1  request, held high until Ack.
- iSlvCmd  in  CMD_W  command: 1 = write, 0 = read.
- iSlvAddr  in  AW  word address.
- iSlvSel  in  SW  byte enables.
- iSlvWData  in  DW  write data.
- oSlvAck  out  1  one-cycle completion pulse.
- oSlvRData  out  DW  read data, valid with Ack of a read.
- iWaitCyc  in  4  extra wait states before Ack, sampled at accept.
- oMemCe  out  1  SRAM chip enable.
- oMemWe  out  1  SRAM write enable.
- oMemAddr  out  AW  SRAM address.
- oMemWData  out  DW  SRAM write data.
- oMemBwe  out  SW  SRAM byte write enables; present only with SRAM_BWE_EN.
- iMemRData  in  DW  SRAM read data, valid one cycle after a read Ce.

Function
REQ-006 SHALL implement an FSM with states IDLE, RD, RDCAP, WR, WAIT and ACK; all outputs SHALL be registered.
REQ-007 In IDLE, iSlvReq=1 SHALL accept the transaction and latch Cmd, Addr, Sel, WData and iWaitCyc. Call the accept cycle N.
REQ-008 The first SRAM access after accept SHALL be as follows:
- Full write (Sel=all ones), or any write with SRAM_BWE_EN: go to WR. Ce=1, We=1 in cycle N+1.
- Read, or partial write without SRAM_BWE_EN: go to RD. Ce=1, We=0 in cycle N+1.
REQ-009 RDCAP (cycle N+2) SHALL capture iMemRData:
- Read: load oSlvRData with the captured data.
- Partial write: build merged word. Bytes with Sel=1 take WData; bytes with Sel=0 take the SRAM data. Go to WR, so the write happens in cycle N+3.
REQ-010 Ce and We SHALL be high for exactly one cycle per SRAM access and low in every other cycle.
REQ-011 After the last SRAM access, the FSM SHALL spend exactly the latched iWaitCyc cycles in WAIT (0..15), then one cycle in ACK with oSlvAck=1.
REQ-012 Latency from accept to Ack with iWaitCyc=0:
- Full write: Ack in cycle N+2.
- Read: Ack in cycle N+3.
- Partial-write RMW: Ack in cycle N+4.
Each wait state adds 1 cycle.
REQ-013 The FSM SHALL return from ACK to IDLE. iSlvReq SHALL be ignored in the ACK cycle; the earliest next accept is the cycle after Ack. The master drops Req in that cycle or presents a new request.
REQ-014 oSlvRData SHALL hold its last read value through writes and idle cycles.
REQ-015 Sel=0 on a write SHALL complete with Ack and perform no SRAM write. Sel=0 on a read SHALL perform a normal read.
REQ-016 Changes on the input buses after accept SHALL NOT affect the transaction in flight.

Reset
REQ-017 While iRst=1, the block SHALL hold the following values:
- FSM in IDLE, wait counter 0.
- oSlvAck=0, oSlvRData=0.
- oMemCe=0, oMemWe=0, oMemAddr=0, oMemWData=0, oMemBwe=0.
REQ-018 Reset asserted mid-transaction SHALL abort it with no Ack. An SRAM access issued in the reset cycle SHALL be suppressed.

Configuration
REQ-019 Macro SRAM_BWE_EN SHALL select the partial-write behaviour:
- Defined: oMemBwe=latched Sel during WR and 0 otherwise; partial writes take a single access, same latency as a full write.
- Undefined: the oMemBwe port is absent; partial writes use RMW (REQ-009).

Verification
REQ-020 Reset check: hold iRst high for 3 cycles with iSlvReq=1 -> Ack, Ce and We stay 0; after release, the first accept occurs in the first cycle with iRst=0.
REQ-021 Full write then read: write Addr=0x005, WData=0xDEADBEEF, Sel=4'hf, wait=0 -> Ce/We at N+1, Ack at N+2. Read back 0x005 -> Ack at N+3 with oSlvRData=0xDEADBEEF.
REQ-022 Partial write: memory at 0x010 preloaded with 0x11223344; write Sel=4'b0101, WData=0xAABBCCDD -> without SRAM_BWE_EN, Ack at N+4 and the word reads back 0x11BB33DD; with SRAM_BWE_EN, Ack at N+2, oMemBwe=4'b0101, same readback value.
REQ-023 Wait states: read with iWaitCyc=5 -> Ack exactly at N+8. Changing iWaitCyc to 0 mid-transaction does not move the Ack.
REQ-024 Back-to-back: 16 reads with Req held continuously and Addr updated after each Ack -> 16 Acks spaced 4 cycles apart, never two Acks in adjacent cycles, all data correct.
REQ-025 Reset mid-RMW: assert iRst in cycle N+2 of a partial write -> no WR access, no Ack, and the memory word is unchanged.
